// File: rtl/div_unsigned_if.sv
// Handshake/operand bundle for div_unsigned.
// master drives start/z/b and observes results; slave is the divider.
interface div_unsigned_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [2*WIDTH-1:0]   z;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     r;
    logic                 err;

    modport master (output start, z, b, input busy, done, q, r, err);
    modport slave  (input start, z, b, output busy, done, q, r, err);
endinterface

// File: rtl/div_unsigned.sv
// Sequential restoring unsigned divider: 2*WIDTH-bit dividend / WIDTH-bit
// divisor, one quotient bit per cycle, WIDTH iterations per operation.
// Optional macro DIV_UNSIGNED_ERR_CHECK_EN: flags divide-by-zero and
// quotient overflow at launch and skips the iterations.
module div_unsigned #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    div_unsigned_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH:0]     rem_q;     // partial remainder
    logic [WIDTH-1:0]   sh_q;      // dividend low bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   r_q;
`ifdef DIV_UNSIGNED_ERR_CHECK_EN
    logic               err_q;
`endif

    logic [WIDTH+1:0]   rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               ge;
    logic [WIDTH:0]     rem_d;
    logic [WIDTH-1:0]   sh_d;

    // One restoring step: bring in the next dividend bit, trial-subtract b.
    always_comb begin
        rem_shift = {rem_q, sh_q[WIDTH-1]};
        ge        = (rem_shift >= {2'b00, b_q});
        rem_diff  = rem_shift[WIDTH:0] - {1'b0, b_q};
        rem_d     = ge ? rem_diff : rem_shift[WIDTH:0];
        sh_d      = {sh_q[WIDTH-2:0], ge};
    end

    // Control FSM plus datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sh_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
`ifdef DIV_UNSIGNED_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        b_q   <= bus.b;
                        rem_q <= {1'b0, bus.z[2*WIDTH-1:WIDTH]};
                        sh_q  <= bus.z[WIDTH-1:0];
                        cnt_q <= '0;
`ifdef DIV_UNSIGNED_ERR_CHECK_EN
                        // A high half >= b means the quotient cannot fit in WIDTH bits.
                        if ((bus.b == '0) || (bus.z[2*WIDTH-1:WIDTH] >= bus.b)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            q_q     <= '0;
                            r_q     <= '0;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= RUN;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        q_q     <= sh_d;
                        r_q     <= rem_d[WIDTH-1:0];
`ifdef DIV_UNSIGNED_ERR_CHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q    = q_q;
    assign bus.r    = r_q;
`ifdef DIV_UNSIGNED_ERR_CHECK_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_div_unsigned.sv
// Directed bench for div_unsigned (WIDTH=4): vector table plus reset-abort,
// back-to-back start and error-check sequences.
module tb_div_unsigned;
    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] z;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unsigned_if #(.WIDTH(W)) bus ();
    div_unsigned #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int       total = 0;
    int       bad   = 0;
    logic [W-1:0] prev_q, prev_r;
    bit       prev_ok;
    vec_t     tbl [12];
    logic [W-1:0] rq, rr;
    logic     re;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Launch one division, measure latency/busy, check q/r hold meanwhile.
    task automatic run_div(input logic [2*W-1:0] z, input logic [W-1:0] b,
                           input int exp_lat,
                           output logic [W-1:0] oq, output logic [W-1:0] orr,
                           output logic oerr);
        int lat;
        int bcnt;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.z = z; bus.b = b;
        lat = 0; bcnt = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 0) begin
                bus.start = 1'b0; bus.z = ~z; bus.b = ~b;
            end
            lat++;
            if (bus.busy) bcnt++;
            if (bus.busy && bus.done) chk("busy_done_overlap", 1, 0);
            if (bus.done) seen = 1;
            else if (prev_ok) begin
                chk("hold_q", int'(bus.q), int'(prev_q));
                chk("hold_r", int'(bus.r), int'(prev_r));
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        chk("latency", lat, exp_lat);
        chk("busy_cycles", bcnt, exp_lat - 1);
        oq = bus.q; orr = bus.r; oerr = bus.err;
        @(negedge clk);
        chk("done_one_cycle", int'(bus.done), 0);
    endtask

    task automatic run_vec(input vec_t v);
        run_div(v.z, v.b, W + 1, rq, rr, re);
        chk($sformatf("q_%0d_%0d", v.z, v.b), int'(rq), int'(v.q));
        chk($sformatf("r_%0d_%0d", v.z, v.b), int'(rr), int'(v.r));
        chk("err_clear", int'(re), 0);
        prev_q = v.q; prev_r = v.r; prev_ok = 1;
    endtask

    initial begin
        int npulse;
        int last;
        int dcnt;
        tbl[0]  = '{8'd225, 4'd15, 4'd15, 4'd0};
        tbl[1]  = '{8'd143, 4'd10, 4'd14, 4'd3};
        tbl[2]  = '{8'd26,  4'd13, 4'd2,  4'd0};
        tbl[3]  = '{8'd239, 4'd15, 4'd15, 4'd14};
        tbl[4]  = '{8'd100, 4'd7,  4'd14, 4'd2};
        tbl[5]  = '{8'd128, 4'd9,  4'd14, 4'd2};
        tbl[6]  = '{8'd47,  4'd3,  4'd15, 4'd2};
        tbl[7]  = '{8'd5,   4'd9,  4'd0,  4'd5};
        tbl[8]  = '{8'd15,  4'd1,  4'd15, 4'd0};
        tbl[9]  = '{8'd1,   4'd1,  4'd1,  4'd0};
        tbl[10] = '{8'd200, 4'd13, 4'd15, 4'd5};
        tbl[11] = '{8'd140, 4'd10, 4'd14, 4'd0};

        bus.start = 1'b0; bus.z = '0; bus.b = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_q", int'(bus.q), 0);
        chk("rst_r", int'(bus.r), 0);
        chk("rst_err", int'(bus.err), 0);
        // start together with rst must be ignored
        bus.start = 1'b1; bus.z = 8'd225; bus.b = 4'd15;
        @(posedge clk); @(negedge clk);
        chk("rst_over_start", int'(bus.busy), 0);
        bus.start = 1'b0;
        rst = 1'b0;
        prev_q = '0; prev_r = '0; prev_ok = 1;

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // Reset two edges after launch aborts the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.z = 8'd225; bus.b = 4'd15;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        chk("abort_busy_pre", int'(bus.busy), 1);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_q", int'(bus.q), 0);
        chk("abort_r", int'(bus.r), 0);
        dcnt = 0;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        prev_q = '0; prev_r = '0;
        run_vec('{8'd0, 4'd15, 4'd0, 4'd0});

        // start held high: one operation every WIDTH+2 cycles; operand
        // changes during RUN must not disturb the running division.
        bus.start = 1'b1; bus.z = 8'd140; bus.b = 4'd10;
        npulse = 0; last = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.busy) begin bus.z = 8'd26; bus.b = 4'd13; end
            if (bus.done) begin
                npulse++;
                chk("cont_gap", c - last, (npulse == 1) ? W + 1 : W + 2);
                chk("cont_q", int'(bus.q), 14);
                chk("cont_r", int'(bus.r), 0);
                last = c;
                bus.z = 8'd140; bus.b = 4'd10;
            end
        end
        chk("cont_pulses", npulse, 3);
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        prev_q = 4'd14; prev_r = 4'd0; prev_ok = 1;

`ifdef DIV_UNSIGNED_ERR_CHECK_EN
        run_div(8'd50, 4'd0, 1, rq, rr, re);
        chk("dz_err", int'(re), 1);
        chk("dz_q", int'(rq), 0);
        chk("dz_r", int'(rr), 0);
        prev_q = '0; prev_r = '0;
        run_div(8'd240, 4'd15, 1, rq, rr, re);
        chk("ovf_err", int'(re), 1);
        chk("ovf_q", int'(rq), 0);
        chk("ovf_r", int'(rr), 0);
        run_vec(tbl[1]);
`else
        run_div(8'd50, 4'd0, W + 1, rq, rr, re);
        chk("dz_err", int'(re), 0);
        prev_ok = 0;
        run_div(8'd240, 4'd15, W + 1, rq, rr, re);
        chk("ovf_err", int'(re), 0);
        run_vec(tbl[1]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/div_unsigned.md
DIV_UNSIGNED -- requirements
Module: div_unsigned

Interface
REQ-001 Parameter: WIDTH, default 4, operand width; dividend is 2*WIDTH bits, divisor, quotient and remainder are WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 z  input  2*WIDTH  dividend (the product operand of the matching multiplier).
REQ-006 b  input  WIDTH  divisor.
REQ-007 busy  output  1  high while iterating (RUN state).
REQ-008 done  output  1  one-cycle pulse; q, r, err valid in that cycle.
REQ-009 q  output  WIDTH  quotient.
REQ-010 r  output  WIDTH  remainder.
REQ-011 err  output  1  divide-by-zero or quotient overflow flag, valid with done.

Function
REQ-012 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1 at edge k; RUN->DONE at edge k+WIDTH; DONE->IDLE on the next edge.
REQ-013 Edge k: latch z and b internally; partial remainder (WIDTH+1 bits) <= z[2*WIDTH-1:WIDTH]; shift register <= z[WIDTH-1:0]; iteration counter <= 0.
REQ-014 Each RUN edge: restoring step -- shift next dividend bit (MSB first) into partial remainder; if partial remainder >= b, subtract b and shift quotient bit 1, else shift 0; counter increments.
REQ-015 Exactly WIDTH iterations; latency start-edge to done-cycle = WIDTH+1 cycles (WIDTH=4: start at edge k, done high in cycle after edge k+4).
REQ-016 Inputs z, b changing after edge k do not affect the running operation.
REQ-017 done=1 only in DONE; busy=1 only in RUN; both never high together.
REQ-018 q, r, err update only on entry to DONE and hold until the next entry to DONE or reset.
REQ-019 start while in RUN or DONE is ignored; start held high in IDLE launches an operation every WIDTH+2 cycles.
REQ-020 For z < (b << WIDTH) and b != 0: q*b + r == z and r < b.
REQ-021 rst=1 at any edge, including mid-RUN, aborts the operation; no done pulse is produced for it.

Reset
REQ-022 On rst: state IDLE, busy=0, done=0, q=0, r=0, err=0, counter and internal registers 0.
REQ-023 rst has priority over start at the same edge.

Configuration
REQ-024 Macro DIV_UNSIGNED_ERR_CHECK_EN defined: at edge k, if b==0 or z[2*WIDTH-1:WIDTH] >= b, FSM goes IDLE->DONE directly (done in cycle after edge k), err=1, q=0, r=0; otherwise err=0 and normal REQ-012..015 flow.
REQ-025 Macro undefined: no check logic; err is constant 0; every start runs the full WIDTH iterations; q and r for b==0 or overflowing inputs are unspecified but done still pulses at WIDTH+1 latency.

Verification (WIDTH=4)
REQ-026 rst=1 two cycles, then start z=225 b=15 -> busy 4 cycles, done pulse 5 cycles after start, q=15 r=0 err=0.
REQ-027 start z=143 b=10 -> q=14 r=3 err=0; then start z=26 b=13 -> q=2 r=0; q/r hold 14/3 until second done.
REQ-028 DIV_UNSIGNED_ERR_CHECK_EN defined: z=50 b=0 -> done one cycle after start, err=1 q=0 r=0; z=240 b=15 -> err=1 (quotient 16 overflows).
REQ-029 start z=225 b=15, rst=1 two edges later -> busy drops next cycle, no done pulse, q=r=0; subsequent z=0 b=15 -> q=0 r=0.
REQ-030 start held high continuously, z=140 b=10 -> done pulses every 6 cycles with q=14 r=0; start pulses during RUN have no effect.
